// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, ALU control encodings and reset PC for the mips core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } aluctl_t;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one clocked write port, r0 hardwired to zero.
module mips_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];

  // Reads see the pre-edge contents, so a same-cycle write is visible only next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 32; k++) regs[k] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/mips.sv
// Single-cycle MIPS subset core (add/sub/and/or/slt/lw/sw/beq/addi/j).
// Define MIPS_ORI_EN to add ori; otherwise opcode 001101 executes as a NOP.
module mips
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  output logic        memwrite,
  output logic [31:0] aluout,
  output logic [31:0] writedata,
  input  logic [31:0] readdata
);

  logic [5:0]  opcode, funct;
  logic        regwrite, regdst, alusrc, memtoreg, branch, jump, memwr, zeroext;
  aluctl_t     aluctl;
  logic [31:0] srca, srcb, imm, signimm, result;
  logic [31:0] pcplus4, pcbranch, pcnext;
  logic [4:0]  writereg;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  // Anything not explicitly decoded leaves every control low, which is a NOP.
  always_comb begin
    regwrite = 1'b0;
    regdst   = 1'b0;
    alusrc   = 1'b0;
    memtoreg = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    memwr    = 1'b0;
    zeroext  = 1'b0;
    aluctl   = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        regdst = 1'b1;
        regwrite = 1'b1;
        case (funct)
          FN_ADD:  aluctl = ALU_ADD;
          FN_SUB:  aluctl = ALU_SUB;
          FN_AND:  aluctl = ALU_AND;
          FN_OR:   aluctl = ALU_OR;
          FN_SLT:  aluctl = ALU_SLT;
          default: regwrite = 1'b0;
        endcase
      end
      OP_LW: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        memtoreg = 1'b1;
      end
      OP_SW: begin
        alusrc = 1'b1;
        memwr  = 1'b1;
      end
      OP_ADDI: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1;
        aluctl = ALU_SUB;
      end
      OP_J: jump = 1'b1;
`ifdef MIPS_ORI_EN
      OP_ORI: begin
        regwrite = 1'b1;
        alusrc   = 1'b1;
        zeroext  = 1'b1;
        aluctl   = ALU_OR;
      end
`endif
      default: ;
    endcase
  end

  mips_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (regwrite),
    .ra1   (instr[25:21]),
    .ra2   (instr[20:16]),
    .wa    (writereg),
    .wd    (result),
    .rd1   (srca),
    .rd2   (writedata)
  );

  assign signimm  = {{16{instr[15]}}, instr[15:0]};
  assign imm      = zeroext ? {16'd0, instr[15:0]} : signimm;
  assign srcb     = alusrc ? imm : writedata;
  assign writereg = regdst ? instr[15:11] : instr[20:16];
  assign result   = memtoreg ? readdata : aluout;

  always_comb begin
    aluout = 32'd0;
    case (aluctl)
      ALU_AND: aluout = srca & srcb;
      ALU_OR:  aluout = srca | srcb;
      ALU_ADD: aluout = srca + srcb;
      ALU_SUB: aluout = srca - srcb;
      ALU_SLT: aluout = ($signed(srca) < $signed(srcb)) ? 32'd1 : 32'd0;
      default: aluout = 32'd0;
    endcase
  end

  // Branch equality is taken straight from the register operands, not the ALU.
  assign pcplus4  = pc + 32'd4;
  assign pcbranch = pcplus4 + (signimm << 2);

  always_comb begin
    pcnext = pcplus4;
    if (jump)
      pcnext = {pcplus4[31:28], instr[25:0], 2'b00};
    else if (branch && (srca == writedata))
      pcnext = pcbranch;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= pcnext;
  end

  assign memwrite = memwr & reset;

endmodule

// File: tb/tb_mips.sv
// Self-checking bench for mips: directed scenarios plus random instruction streams
// checked against an architectural model (register array + pc).
module tb_mips;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mregs [32];
  logic [31:0] mpc;
  logic [31:0] sampAlu, sampWd;
  logic        sampMw;

  mips dut (
    .clk       (clk),
    .reset     (reset),
    .pc        (pc),
    .instr     (instr),
    .memwrite  (memwrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h (pc model=%h)", tag, obs, exp, mpc);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
    mpc = 32'd0;
  endtask

  // Execute one instruction: predict from architectural rules, sample mid-cycle, then clock.
  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] rdata);
    logic [31:0] a, b, se, ze, npc, expalu, wval;
    logic        chk, we, mw;
    logic [4:0]  wreg;
    instr    = i;
    readdata = rdata;
    a   = mregs[i[25:21]];
    b   = mregs[i[20:16]];
    se  = {{16{i[15]}}, i[15:0]};
    ze  = {16'd0, i[15:0]};
    npc = mpc + 32'd4;
    chk = 1'b0; we = 1'b0; mw = 1'b0;
    wreg = i[20:16]; expalu = 32'd0; wval = 32'd0;
    case (i[31:26])
      6'b000000: begin
        wreg = i[15:11]; chk = 1'b1; we = 1'b1;
        case (i[5:0])
          6'b100000: expalu = a + b;
          6'b100010: expalu = a - b;
          6'b100100: expalu = a & b;
          6'b100101: expalu = a | b;
          6'b101010: expalu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin chk = 1'b0; we = 1'b0; end
        endcase
        wval = expalu;
      end
      6'b100011: begin chk = 1'b1; expalu = a + se; we = 1'b1; wval = rdata; end
      6'b101011: begin chk = 1'b1; expalu = a + se; mw = 1'b1; end
      6'b001000: begin chk = 1'b1; expalu = a + se; we = 1'b1; wval = expalu; end
      6'b000100: if (a == b) npc = mpc + 32'd4 + (se << 2);
      6'b000010: npc = {npc[31:28], i[25:0], 2'b00};
`ifdef MIPS_ORI_EN
      6'b001101: begin chk = 1'b1; expalu = a | ze; we = 1'b1; wval = expalu; end
`endif
      default: ;
    endcase
    #2;
    sampAlu = aluout; sampMw = memwrite; sampWd = writedata;
    if (chk) checkOutput("aluout", aluout, expalu);
    checkOutput("memwrite", {31'd0, memwrite}, {31'd0, mw});
    checkOutput("writedata", writedata, b);
    @(posedge clk);
    #1;
    if (we && (wreg != 5'd0)) mregs[wreg] = wval;
    mpc = npc;
    checkOutput("pc", pc, mpc);
  endtask

  function automatic logic [31:0] randInstr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  fn;
    logic [5:0]  badops [4];
    badops[0] = 6'b000101; badops[1] = 6'b111111;
    badops[2] = 6'b001111; badops[3] = 6'b100000;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 11))
      0:  fn = 6'b100000;
      1:  fn = 6'b100010;
      2:  fn = 6'b100100;
      3:  fn = 6'b100101;
      4:  fn = 6'b101010;
      default: fn = 6'b100001;
    endcase
    case ($urandom_range(0, 11))
      0, 1, 2: return {6'b000000, rs, rt, rd, 5'd0, fn};
      3:       return {6'b100011, rs, rt, imm};
      4:       return {6'b101011, rs, rt, imm};
      5:       return {6'b000100, rs, rt, imm};
      6, 7:    return {6'b001000, rs, rt, imm};
      8:       return {6'b000010, 26'($urandom)};
      9:       return {6'b001101, rs, rt, imm};
      10:      return {badops[$urandom_range(0, 3)], rs, rt, imm};
      default: return {6'b000000, rs, rt, rd, 5'd0, 6'b100001};
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    instr = 32'hAC01_0004;
    readdata = 32'd0;
    modelReset();
    #12;
    checkOutput("reset pc", pc, 32'd0);
    checkOutput("reset memwrite", {31'd0, memwrite}, 32'd0);
    @(posedge clk); #1;
    checkOutput("reset pc held", pc, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(32'h1022_0002, 32'd0);
    checkOutput("beq taken pc", pc, 32'h0000_000C);
    applyStimulus(32'h0800_0008, 32'd0);
    checkOutput("j pc", pc, 32'h0000_0020);
    applyStimulus(32'h2001_0005, 32'd0);
    applyStimulus(32'hAC01_0004, 32'd0);
    checkOutput("sw memwrite", {31'd0, sampMw}, 32'd1);
    checkOutput("sw aluout", sampAlu, 32'd4);
    checkOutput("sw writedata", sampWd, 32'd5);
    applyStimulus(32'h8C02_0000, 32'hDEAD_BEEF);
    begin
      logic [31:0] pcBefore;
      pcBefore = pc;
      applyStimulus(32'h1042_0001, 32'd0);
      checkOutput("beq r2 advance", pc, pcBefore + 32'd8);
    end
    applyStimulus(32'h0002_1822, 32'd0);
    checkOutput("sub aluout", sampAlu, 32'h2152_4111);

    applyStimulus(32'h0800_0008, 32'd0);
    checkOutput("j pc again", pc, 32'h0000_0020);
    instr = 32'hAC01_0004;
    reset = 1'b0;
    #1;
    checkOutput("async reset pc", pc, 32'd0);
    checkOutput("async reset memwrite", {31'd0, memwrite}, 32'd0);
    modelReset();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(32'h0022_2020, 32'd0);
    checkOutput("post-reset add", sampAlu, 32'd0);
    checkOutput("post-reset pc", pc, 32'd4);

    applyStimulus(32'h3405_8001, 32'd0);
    checkOutput("ori pc", pc, 32'd8);
    applyStimulus(32'h00A0_3020, 32'd0);
`ifdef MIPS_ORI_EN
    checkOutput("ori result", sampAlu, 32'h0000_8001);
`else
    checkOutput("ori nop", sampAlu, 32'h0000_0000);
`endif

    for (int n = 0; n < 300; n++) begin
      applyStimulus(randInstr(), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
